// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: frame format,
// oversampling ratio and the receiver FSM states.
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int TICK_W     = 4;
    localparam int BURST_W    = 15;
    localparam int COUNT_W    = 16;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rxState_e;
endpackage

// File: rtl/uart_receiver_if.sv
// Burst-control and data signals between the UART receiver and its client.
interface uart_receiver_if #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS
);
    logic                         sample_tick;
    logic                         rx;
    logic                         start;
    logic [uart_pkg::BURST_W-1:0] num_bytes_to_receive;
    logic [DATA_BITS-1:0]         rx_data;
    logic                         rx_valid;
    logic                         frame_error;
    logic [uart_pkg::COUNT_W-1:0] data_counter;
    logic                         busy;
    logic                         done;

    modport master (
        output sample_tick, rx, start, num_bytes_to_receive,
        input  rx_data, rx_valid, frame_error, data_counter, busy, done
    );

    modport slave (
        input  sample_tick, rx, start, num_bytes_to_receive,
        output rx_data, rx_valid, frame_error, data_counter, busy, done
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing a single asynchronous bit into the clk domain.
module sync_2ff #(
    parameter logic RESET_VALUE = uart_pkg::IDLE_LEVEL
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver with burst control: once armed by start it
// accepts frames until the latched number of good bytes has been received.
module uart_receiver #(
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int DATA_BITS  = uart_pkg::DATA_BITS
) (
    input  logic           system_clock,
    input  logic           rst,
    uart_receiver_if.slave bus
);
    import uart_pkg::*;

    localparam int                BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    rxState_e             state_q, state_d;
    logic [TICK_W-1:0]    tickCnt_q, tickCnt_d;
    logic [BIT_W-1:0]     bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;

    logic                 rxSync;
    logic                 rxPrev_q;
    logic                 armEdge;
    logic                 sampleNow;
    logic                 frameGood;
    logic                 frameBad;

    logic [DATA_BITS-1:0] rxData_q;
    logic                 rxValid_q;
    logic                 frameError_q;
    logic [COUNT_W-1:0]   dataCounter_q;
    logic [BURST_W-1:0]   byteTarget_q;
    logic                 busy_q;
    logic                 done_q;

    sync_2ff #(
        .RESET_VALUE(IDLE_LEVEL)
    ) rxSyncInst (
        .clk(system_clock),
        .rst(rst),
        .d_i(bus.rx),
        .q_o(rxSync)
    );

    // A start bit is only recognised while a burst is armed.
    assign armEdge   = busy_q && rxPrev_q && !rxSync;
    assign sampleNow = bus.sample_tick && (tickCnt_q == MID_TICK);

    always_ff @(posedge system_clock) begin
        if (rst) begin
            state_q   <= IDLE;
            tickCnt_q <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            rxPrev_q  <= IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            tickCnt_q <= tickCnt_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            rxPrev_q  <= rxSync;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (armEdge) state_d = START;
            START:     if (sampleNow) state_d = (rxSync == START_BIT) ? DATA : IDLE;
            DATA:      if (sampleNow && (bitCnt_q == LAST_BIT)) state_d = STOP;
            STOP:      if (sampleNow) state_d = (rxSync == STOP_BIT) ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rxSync == IDLE_LEVEL) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        tickCnt_d = tickCnt_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        frameGood = 1'b0;
        frameBad  = 1'b0;
        if (bus.sample_tick) begin
            tickCnt_d = (tickCnt_q == LAST_TICK) ? '0 : tickCnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                bitCnt_d = '0;
                if (armEdge) tickCnt_d = '0;
            end
            START: bitCnt_d = '0;
            DATA: begin
                if (sampleNow) begin
                    shift_d  = DATA_BITS'({rxSync, shift_q} >> 1);
                    bitCnt_d = bitCnt_q + 1'b1;
                end
            end
            STOP: begin
                frameGood = sampleNow && (rxSync == STOP_BIT);
                frameBad  = sampleNow && (rxSync != STOP_BIT);
            end
            default: ;
        endcase
    end

    // Burst bookkeeping; a frame can only complete while busy, so it never collides with an accepted start.
    always_ff @(posedge system_clock) begin
        if (rst) begin
            rxData_q      <= '0;
            rxValid_q     <= 1'b0;
            frameError_q  <= 1'b0;
            dataCounter_q <= '0;
            byteTarget_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            rxValid_q    <= frameGood;
            frameError_q <= frameBad;
            if (frameGood) begin
                rxData_q      <= shift_q;
                dataCounter_q <= dataCounter_q + 1'b1;
                if ((dataCounter_q + 1'b1) == {1'b0, byteTarget_q}) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
            if (bus.start && !busy_q) begin
                dataCounter_q <= '0;
                byteTarget_q  <= bus.num_bytes_to_receive;
                busy_q        <= (bus.num_bytes_to_receive != '0);
                done_q        <= (bus.num_bytes_to_receive == '0);
            end
        end
    end

    assign bus.rx_data      = rxData_q;
    assign bus.rx_valid     = rxValid_q;
    assign bus.frame_error  = frameError_q;
    assign bus.data_counter = dataCounter_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: a frame-level model predicts every
// accepted byte, error pulse and burst flag from what the transmitter sends.
module tb_uart_receiver;
    import uart_pkg::*;

    typedef struct {
        logic [7:0] data;
        bit         last;
        int         count;
    } expByte_t;

    logic system_clock = 1'b0;
    logic rst = 1'b1;

    uart_receiver_if #(.DATA_BITS(8)) bus();

    uart_receiver #(
        .OVERSAMPLE(16),
        .DATA_BITS(8)
    ) dut (
        .system_clock(system_clock),
        .rst(rst),
        .bus(bus)
    );

    int compareCount = 0;
    int mismatchCount = 0;

    // Tick spacing is compressed relative to a real baud divider to keep the run short.
    int tickPeriod = 2;
    int tickDiv = 0;

    expByte_t   expQ[$];
    expByte_t   seenByte;
    bit         modelBusy;
    bit         modelDone;
    int         modelCount;
    int         modelTarget;
    logic [7:0] lastGood;
    int         expFrameErr;
    int         seenFrameErr;

    always #5 system_clock = ~system_clock;

    always @(negedge system_clock) begin
        if (tickDiv >= tickPeriod - 1) begin
            tickDiv = 0;
            bus.sample_tick = 1'b1;
        end else begin
            tickDiv = tickDiv + 1;
            bus.sample_tick = 1'b0;
        end
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every rx_valid must match the oldest byte the model predicted.
    always @(negedge system_clock) begin
        if (bus.rx_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("rx_valid_expected", 32'(bus.rx_valid), 32'd0);
            end else begin
                seenByte = expQ.pop_front();
                checkOutput("rx_data", 32'(bus.rx_data), 32'(seenByte.data));
                checkOutput("data_counter_at_valid", 32'(bus.data_counter), 32'(seenByte.count));
                checkOutput("done_at_valid", 32'(bus.done), 32'(seenByte.last));
                checkOutput("busy_at_valid", 32'(bus.busy), 32'(!seenByte.last));
                lastGood = seenByte.data;
            end
        end
        if (bus.frame_error === 1'b1) begin
            seenFrameErr++;
            checkOutput("rx_data_held_on_error", 32'(bus.rx_data), 32'(lastGood));
        end
    end

    task automatic modelReset();
        expQ.delete();
        modelBusy    = 1'b0;
        modelDone    = 1'b0;
        modelCount   = 0;
        modelTarget  = 0;
        lastGood     = 8'h00;
        expFrameErr  = 0;
        seenFrameErr = 0;
    endtask

    task automatic waitTicks(input int n);
        int seen = 0;
        while (seen < n) begin
            @(posedge system_clock);
            if (bus.sample_tick) seen++;
        end
        @(negedge system_clock);
    endtask

    task automatic applyStimulus(input int count);
        @(negedge system_clock);
        bus.start = 1'b1;
        bus.num_bytes_to_receive = 15'(count);
        if (!modelBusy) begin
            modelTarget = count;
            modelCount  = 0;
            modelBusy   = (count != 0);
            modelDone   = (count == 0);
        end
        @(negedge system_clock);
        bus.start = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] data, input bit stopBit, input int gapTicks);
        expByte_t e;
        if (modelBusy) begin
            if (stopBit) begin
                modelCount++;
                e.data  = data;
                e.count = modelCount;
                e.last  = (modelCount == modelTarget);
                expQ.push_back(e);
                if (e.last) begin
                    modelBusy = 1'b0;
                    modelDone = 1'b1;
                end
            end else begin
                expFrameErr++;
            end
        end
        bus.rx = 1'b0;
        waitTicks(16);
        for (int i = 0; i < 8; i++) begin
            bus.rx = data[i];
            waitTicks(16);
        end
        bus.rx = stopBit;
        waitTicks(16);
        bus.rx = 1'b1;
        waitTicks(gapTicks);
    endtask

    task automatic checkBurstEnd(input string tag);
        checkOutput({tag, "_data_counter"}, 32'(bus.data_counter), 32'(modelCount));
        checkOutput({tag, "_done"}, 32'(bus.done), 32'(modelDone));
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'(modelBusy));
        checkOutput({tag, "_pending_bytes"}, 32'(expQ.size()), 32'd0);
        checkOutput({tag, "_frame_errors"}, 32'(seenFrameErr), 32'(expFrameErr));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
        checkOutput({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
        checkOutput({tag, "_frame_error"}, 32'(bus.frame_error), 32'd0);
        checkOutput({tag, "_data_counter"}, 32'(bus.data_counter), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
    endtask

    initial begin
        logic [7:0] partial;
        bus.rx = 1'b1;
        bus.start = 1'b0;
        bus.num_bytes_to_receive = '0;
        modelReset();
        repeat (4) @(negedge system_clock);
        checkResetOutputs("por");
        rst = 1'b0;
        waitTicks(4);

        $display("[TB] zero-length burst");
        checkOutput("done_before_zero_start", 32'(bus.done), 32'(modelDone));
        applyStimulus(0);
        checkOutput("done_after_zero_start", 32'(bus.done), 32'(modelDone));
        checkOutput("busy_after_zero_start", 32'(bus.busy), 32'(modelBusy));
        sendFrame(8'($urandom), 1'b1, 2);
        checkBurstEnd("zero");

        $display("[TB] loopback burst of ten");
        applyStimulus(10);
        repeat (10) sendFrame(8'h11, 1'b1, 2);
        sendFrame(8'h11, 1'b1, 2);
        checkBurstEnd("loopback");

        $display("[TB] frame error then good frame");
        applyStimulus(1);
        sendFrame(8'hA5, 1'b0, 3);
        checkOutput("fe_counter_unchanged", 32'(bus.data_counter), 32'(modelCount));
        checkOutput("fe_pulse_count", 32'(seenFrameErr), 32'(expFrameErr));
        sendFrame(8'h3C, 1'b1, 2);
        checkBurstEnd("frame_error");

        $display("[TB] glitch on idle line");
        applyStimulus(1);
        bus.rx = 1'b0;
        waitTicks(4);
        bus.rx = 1'b1;
        waitTicks(20);
        checkOutput("glitch_state", 32'(dut.state_q), 32'(IDLE));
        checkBurstEnd("glitch");
        sendFrame(8'($urandom), 1'b1, 2);
        checkBurstEnd("after_glitch");

        $display("[TB] start while busy");
        applyStimulus(3);
        sendFrame(8'($urandom), 1'b1, 2);
        applyStimulus(1);
        checkOutput("ignored_start_counter", 32'(bus.data_counter), 32'(modelCount));
        checkOutput("ignored_start_busy", 32'(bus.busy), 32'(modelBusy));
        repeat (2) sendFrame(8'($urandom), 1'b1, 2);
        checkBurstEnd("start_busy");

        $display("[TB] random bursts");
        for (int b = 0; b < 3; b++) begin
            applyStimulus(int'($urandom_range(3, 6)));
            for (int f = 0; f < 24 && modelBusy; f++) begin
                sendFrame(8'($urandom), $urandom_range(0, 4) != 0, int'($urandom_range(1, 6)));
            end
            checkBurstEnd("random_burst");
        end

        $display("[TB] reset in the middle of a frame");
        applyStimulus(2);
        partial = 8'($urandom);
        bus.rx = 1'b0;
        waitTicks(16);
        for (int i = 0; i < 3; i++) begin
            bus.rx = partial[i];
            waitTicks(16);
        end
        rst = 1'b1;
        @(negedge system_clock);
        checkResetOutputs("midframe");
        bus.rx = 1'b1;
        rst = 1'b0;
        modelReset();
        waitTicks(20);
        applyStimulus(2);
        repeat (2) sendFrame(8'h55, 1'b1, 2);
        checkBurstEnd("after_reset");

        $display("[TB] burst of 256");
        tickPeriod = 1;
        applyStimulus(256);
        repeat (256) sendFrame(8'h25, 1'b1, 1);
        checkBurstEnd("burst256");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter OVERSAMPLE, default 16, sample_tick pulses per bit period.
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame.
REQ-003 system_clock  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sample_tick  input  1  one-cycle enable at OVERSAMPLE x baud, from an oversampling clock divider.
REQ-006 rx  input  1  serial line, asynchronous to system_clock, idle high.
REQ-007 start  input  1  one-cycle pulse that arms a burst reception.
REQ-008 num_bytes_to_receive  input  15  burst length, sampled on start.
REQ-009 rx_data  output  DATA_BITS  last received byte.
REQ-010 rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-011 frame_error  output  1  one-cycle pulse, stop bit sampled low.
REQ-012 data_counter  output  16  good bytes received in the current burst.
REQ-013 busy  output  1  high while a burst is armed.
REQ-014 done  output  1  high from burst completion until the next start or reset.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value.
REQ-016 Frame format SHALL be 8N1: one low start bit, DATA_BITS data bits LSB first, one high stop bit.
REQ-017 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-018 IDLE -> START SHALL occur on a synchronized falling edge while busy=1; the tick counter clears to 0.
REQ-019 A 4-bit tick counter SHALL advance only on sample_tick; a bit is sampled when the counter equals OVERSAMPLE/2-1 in START, and at each further OVERSAMPLE ticks.
REQ-020 START sample = 1 SHALL be treated as a glitch: return to IDLE, nothing counted.
REQ-021 DATA SHALL shift in DATA_BITS samples, then go to STOP.
REQ-022 STOP sample = 1: rx_data updates, rx_valid pulses on the next system_clock cycle, data_counter increments, and the FSM returns to IDLE.
REQ-023 STOP sample = 0: frame_error pulses, rx_data is unchanged, data_counter is unchanged, and the FSM goes to WAIT_IDLE.
REQ-024 WAIT_IDLE SHALL exit to IDLE only after the synchronized rx is seen high.
REQ-025 start SHALL clear data_counter and done, latch num_bytes_to_receive, and set busy.
REQ-026 When data_counter reaches the latched count, busy SHALL drop and done SHALL rise in the same cycle as the final rx_valid.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 A latched count of 0 SHALL set done on the cycle after start, with no reception.
REQ-029 Falling edges while busy=0 SHALL be ignored: the FSM stays in IDLE and no frame is decoded.
REQ-030 data_counter SHALL be 16 bits and SHALL never wrap, because the maximum count is 32767.

Reset
REQ-031 On rst=1 at a clock edge: FSM to IDLE, synchronizer to 1, tick/bit counters 0, rx_data 0, rx_valid 0, frame_error 0, data_counter 0, busy 0, done 0, latched count 0.
REQ-032 rst SHALL override start and every in-flight frame; a partial frame is discarded and no pulse is emitted.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state enum, OVERSAMPLE, DATA_BITS and the frame-format constants, shared with the transmitter.
REQ-034 The synchronizer SHALL be a separate sub-module, sync_2ff; everything else SHALL be in one module.
REQ-035 Oversampling tick generation SHALL stay outside this block.

Verification
REQ-036 Bench: 100 MHz system_clock; sample_tick every 54 cycles (115200 baud x16); rx bit period 16 ticks.
REQ-037 Loopback: start with count 10; transmitter sends 10 x 8'h11 -> ten rx_valid pulses with rx_data 8'h11, data_counter 10, done=1, busy=0.
REQ-038 Frame error: one frame with payload 8'hA5 and stop bit 0 -> exactly one frame_error pulse, no rx_valid, data_counter unchanged; the next good frame 8'h3C is accepted.
REQ-039 Glitch: rx low for 4 ticks then high -> no rx_valid, no frame_error, FSM back in IDLE.
REQ-040 Boundaries: count 0 -> done on the cycle after start; count 256 of 8'h25 -> data_counter 256; start while busy -> ignored.
REQ-041 Reset mid-frame after 3 data bits -> all outputs 0 next cycle; a following burst of 2 x 8'h55 -> both bytes received correctly.
